// File: rtl/control_wall.sv
// Wall sequencer: on each frame tick, erase the wall, move it, redraw it,
// and bump the score when it wraps past the left edge. All outputs are registered.
module control_wall #(
    parameter int WALL_WIDTH   = 10,
    parameter int SCREEN_H     = 120,
    parameter int WALL_X_SPEED = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] wall_x,
    output logic [1:0] alu_select,
    output logic       ld_wall,
    output logic       ld_score,
    output logic       plot,
    output logic [3:0] x_off,
    output logic [6:0] y_off,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEL,
        S_UPDATE,
        S_DRAW,
        S_SCORE
    } state_t;

    localparam logic [1:0] ALU_UPDATE = 2'd0;
    localparam logic [1:0] ALU_DEL    = 2'd1;
    localparam logic [1:0] ALU_DRAW   = 2'd2;
    localparam logic [1:0] ALU_SCORE  = 2'd3;

    localparam logic [3:0] X_LAST = 4'(WALL_WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
    localparam logic [8:0] SPEED  = 9'(WALL_X_SPEED);

    state_t     state_q, state_d;
    logic       pending_q, pending_d;
    logic       wrap_q, wrap_d;
    logic [1:0] alu_q, alu_d;
    logic       ld_wall_q, ld_wall_d;
    logic       ld_score_q, ld_score_d;
    logic       plot_q, plot_d;
    logic [3:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       last_px;
    logic [3:0] x_nxt;
    logic [6:0] y_nxt;

    // Raster scan: x inner, y outer; x wraps at the wall width, not at the counter width.
    always_comb begin
        last_px = (x_q == X_LAST) && (y_q == Y_LAST);
        x_nxt   = x_q + 4'd1;
        y_nxt   = y_q;
        if (x_q == X_LAST) begin
            x_nxt = 4'd0;
            y_nxt = y_q + 7'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        wrap_d     = wrap_q;
        alu_d      = ALU_UPDATE;
        ld_wall_d  = 1'b0;
        ld_score_d = 1'b0;
        plot_d     = 1'b0;
        x_d        = 4'd0;
        y_d        = 7'd0;
        done_d     = 1'b0;

        // Only one tick can be remembered while a sequence is in flight.
        if (frame_tick && state_q != S_IDLE) pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (frame_tick || pending_q) begin
                    state_d   = S_DEL;
                    pending_d = 1'b0;
                    alu_d     = ALU_DEL;
                    plot_d    = 1'b1;
                end
            end
            S_DEL: begin
                if (last_px) begin
                    state_d   = S_UPDATE;
                    ld_wall_d = 1'b1;
                end else begin
                    alu_d  = ALU_DEL;
                    plot_d = 1'b1;
                    x_d    = x_nxt;
                    y_d    = y_nxt;
                end
            end
            S_UPDATE: begin
                wrap_d  = ({1'b0, wall_x} < SPEED);
                state_d = S_DRAW;
                alu_d   = ALU_DRAW;
                plot_d  = 1'b1;
            end
            S_DRAW: begin
                if (last_px) begin
                    if (wrap_q) begin
                        state_d    = S_SCORE;
                        alu_d      = ALU_SCORE;
                        ld_score_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    alu_d  = ALU_DRAW;
                    plot_d = 1'b1;
                    x_d    = x_nxt;
                    y_d    = y_nxt;
                end
            end
            S_SCORE: begin
                wrap_d  = 1'b0;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            wrap_q     <= 1'b0;
            alu_q      <= ALU_UPDATE;
            ld_wall_q  <= 1'b0;
            ld_score_q <= 1'b0;
            plot_q     <= 1'b0;
            x_q        <= 4'd0;
            y_q        <= 7'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            wrap_q     <= wrap_d;
            alu_q      <= alu_d;
            ld_wall_q  <= ld_wall_d;
            ld_score_q <= ld_score_d;
            plot_q     <= plot_d;
            x_q        <= x_d;
            y_q        <= y_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign alu_select = alu_q;
    assign ld_wall    = ld_wall_q;
    assign ld_score   = ld_score_q;
    assign plot       = plot_q;
    assign x_off      = x_q;
    assign y_off      = y_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/control_wall.md
# control_wall

Sequencing controller for the wall datapath in the flappy-style game. Each frame tick it drives the wall datapath through four steps: erase the wall at its old position, move it left, redraw it, and bump the score if the wall wrapped past the left edge. It generates the ALU/operation select, per-pixel plot strobes, and the rectangle pixel offsets that the datapath adds to `wall_x`/y to form VGA coordinates. It sits between the frame-rate divider and the shared VGA plot mux.

## Interface
Parameters
- `WALL_WIDTH`, default 10: wall thickness in pixels, columns per pass. Must be 1..16.
- `SCREEN_H`, default 120: rows per pass. Must be 1..128.
- `WALL_X_SPEED`, default 4: pixels moved per update; used only for wrap detection.

Ports
- `clk` input 1: system clock. All logic is rising-edge.
- `reset` input 1: synchronous, active-high.
- `frame_tick` input 1: one-cycle pulse requesting one wall update sequence.
- `wall_x` input 8: current wall x position from the datapath, read before the update.
- `alu_select` output 2: datapath operation. 0 = UPDATE_WALL, 1 = DEL_WALL, 2 = DRAW_WALL, 3 = UPDATE_SCORE.
- `ld_wall` output 1: datapath commits `wall_x - WALL_X_SPEED` this cycle.
- `ld_score` output 1: datapath increments the score this cycle.
- `plot` output 1: the current pixel (`x_off`, `y_off`) is valid to write.
- `x_off` output 4: column offset within the wall, 0..WALL_WIDTH-1.
- `y_off` output 7: row offset, 0..SCREEN_H-1.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a sequence completes.

## Operation
- States: IDLE, DEL, UPDATE, DRAW, SCORE. All outputs are registered.
- Reset values:
  - state = IDLE; `alu_select` = 0.
  - `ld_wall`, `ld_score`, `plot`, `busy`, `done` = 0.
  - `x_off` = `y_off` = 0.
  - `pending` = 0; `wrap` = 0.
- Transitions:
  - IDLE goes to DEL when `frame_tick` or `pending` is set. `pending` clears on this transition.
  - DEL: `alu_select` = 1 and `plot` = 1 every cycle. Offsets scan x-inner, y-outer. After the pixel (WALL_WIDTH-1, SCREEN_H-1), offsets reset to 0 and the state goes to UPDATE.
  - UPDATE lasts one cycle: `alu_select` = 0, `ld_wall` = 1. In this cycle `wrap` is set to (`wall_x` < WALL_X_SPEED). Next state is DRAW.
  - DRAW: same scan as DEL with `alu_select` = 2. After the last pixel, go to SCORE if `wrap`, else go to IDLE.
  - SCORE lasts one cycle: `alu_select` = 3, `ld_score` = 1, `wrap` clears. Next state is IDLE.
- `done` pulses for one cycle on the first IDLE cycle after DRAW or SCORE.
- Tick handling:
  - A `frame_tick` while `busy` sets `pending`. At most one tick is queued; further ticks while `pending` is set are dropped.
  - A tick that coincides with the `done` cycle is accepted directly (IDLE goes to DEL next edge).
- When `plot` is 0, offsets are held at 0.
- Counter width rules: `x_off` wraps at WALL_WIDTH-1, never at 15. `y_off` increments only when `x_off` wraps.
- Reset asserted in any state: the next edge forces the full reset values. A queued tick and `wrap` are discarded, and no `ld_*` strobe fires on that edge.

## Timing
- Tick sampled at edge 0 gives the first DEL pixel (`plot` = 1) on cycle 1.
- DEL occupies cycles 1..N, where N = WALL_WIDTH × SCREEN_H (1200 by default).
- UPDATE is at cycle N+1. DRAW occupies N+2..2N+1.
- SCORE, if taken, is at 2N+2.
- `done` falls at 2N+2 without wrap, or 2N+3 with wrap.
- Sequence latency is therefore 2N+1 busy cycles (2401 by default), plus 1 if wrapping.
- Exactly one `ld_wall` pulse per sequence; at most one `ld_score` pulse.
- `ld_wall`, `ld_score` and `plot` are mutually exclusive every cycle.

## Test plan
- Reset, idle. Hold `reset` 2 cycles, no ticks → all outputs 0 and `busy` = 0 indefinitely.
- Basic sequence. WALL_WIDTH = 2, SCREEN_H = 3, `wall_x` = 100, one tick:
  - DEL for 6 cycles with offsets (0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
  - 1 UPDATE cycle with `ld_wall` = 1.
  - 6 DRAW cycles.
  - `done` on cycle 14; `ld_score` never asserted.
- Wrap. Same parameters, `wall_x` = 3 (< 4) → SCORE cycle 14 with `alu_select` = 3 and `ld_score` = 1, then `done` on cycle 15.
- Tick queuing. Ticks at cycles 0, 5 and 7 while busy → exactly two sequences run back-to-back. The second DEL starts on the cycle after the first `done`. The tick at cycle 7 is dropped.
- Tick on the `done` cycle. Next sequence starts the following cycle; no lost or doubled sequence.
- Reset mid-DRAW. Assert `reset` at offset (1,1) of DRAW with a queued tick → next cycle is IDLE with all outputs 0, and no further sequence runs without a new tick.
